// File: rtl/sie_rx_pkt_if.sv
// PHY-to-decoder receive strobe bus: one byte, EOP or error status per rx_ready cycle.
// master = receive PHY side, slave = packet decoder side.
interface sie_rx_pkt_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, output rx_err, output rx_ready);
  modport slave  (input  rx_data, input  rx_valid, input  rx_err, input  rx_ready);
endinterface

// File: rtl/sie_rx_pkt.sv
// USB full-speed receive packet decoder: PID check, token CRC5, data CRC16, field/payload extraction.
// Optional device-address token filter enabled by defining SIE_RX_ADDR_FILTER_EN.
module sie_rx_pkt #(
  parameter int MAX_PKT = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  sie_rx_pkt_if.slave phy,
  input  logic        usb_reset_i,
  input  logic [6:0]  dev_addr_i,
  output logic [3:0]  pid_o,
  output logic [6:0]  addr_o,
  output logic [3:0]  endp_o,
  output logic [10:0] frame_o,
  output logic        token_valid_o,
  output logic        hsk_valid_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        data_end_o,
  output logic        data_ok_o,
  output logic        pkt_err_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TOKEN = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_HSK   = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  localparam int CNT_W = $clog2(MAX_PKT + 4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_PKT + 2);

  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'h06;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'hB001;
  localparam logic [3:0]  PID_SOF     = 4'h5;

  // Reflected CRCs: bit 0 of each byte is the first bit on the bus.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [10:0]      frame_q, frame_d;
  logic [7:0]       tok_lo_q, tok_lo_d;
  logic [2:0]       tok_hi_q, tok_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [7:0]       dly0_q, dly0_d;
  logic [7:0]       dly1_q, dly1_d;
  logic [7:0]       data_q, data_d;
  logic             token_valid_q, token_valid_d;
  logic             hsk_valid_q, hsk_valid_d;
  logic             data_valid_q, data_valid_d;
  logic             data_end_q, data_end_d;
  logic             data_ok_q, data_ok_d;
  logic             pkt_err_q, pkt_err_d;

  logic             is_byte, is_eop, is_err;
  logic             pid_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic             tok_addr_ok;
  logic             data_good;

  assign is_byte = phy.rx_ready &  phy.rx_valid & ~phy.rx_err;
  assign is_err  = phy.rx_ready &  phy.rx_err;
  assign is_eop  = phy.rx_ready & ~phy.rx_valid & ~phy.rx_err;

  assign pid_ok    = (phy.rx_data[7:4] == ~phy.rx_data[3:0]);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign data_good = (crc16_q == CRC16_RESID) && (cnt_q >= CNT_TWO) && (cnt_q <= LEN_MAX);

`ifdef SIE_RX_ADDR_FILTER_EN
  // Tokens for other devices vanish silently; SOF is broadcast.
  assign tok_addr_ok = (pid_q == PID_SOF) || (tok_lo_q[6:0] == dev_addr_i);
`else
  logic unused_dev_addr;
  assign unused_dev_addr = ^dev_addr_i;
  assign tok_addr_ok     = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q (or 0 for pulses) so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    pid_d         = pid_q;
    addr_d        = addr_q;
    endp_d        = endp_q;
    frame_d       = frame_q;
    tok_lo_d      = tok_lo_q;
    tok_hi_d      = tok_hi_q;
    cnt_d         = cnt_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    dly0_d        = dly0_q;
    dly1_d        = dly1_q;
    data_d        = data_q;
    token_valid_d = 1'b0;
    hsk_valid_d   = 1'b0;
    data_valid_d  = 1'b0;
    data_end_d    = 1'b0;
    data_ok_d     = 1'b0;
    pkt_err_d     = 1'b0;

    if (usb_reset_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      crc5_d  = CRC5_INIT;
      crc16_d = CRC16_INIT;
      dly0_d  = '0;
      dly1_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_byte) begin
            cnt_d   = '0;
            crc5_d  = CRC5_INIT;
            crc16_d = CRC16_INIT;
            if (pid_ok) begin
              pid_d = phy.rx_data[3:0];
              case (phy.rx_data[1:0])
                2'b01:   state_d = ST_TOKEN;
                2'b11:   state_d = ST_DATA;
                2'b10:   state_d = ST_HSK;
                default: begin
                  pkt_err_d = 1'b1;
                  state_d   = ST_DROP;
                end
              endcase
            end else begin
              pkt_err_d = 1'b1;
              state_d   = ST_DROP;
            end
          end
        end

        ST_TOKEN: begin
          if (is_err) begin
            pkt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (is_byte) begin
            if (cnt_q == CNT_TWO) begin
              pkt_err_d = 1'b1;
              state_d   = ST_DROP;
            end else begin
              crc5_d = crc5_byte(crc5_q, phy.rx_data);
              cnt_d  = cnt_inc;
              if (cnt_q == '0) tok_lo_d = phy.rx_data;
              else             tok_hi_d = phy.rx_data[2:0];
            end
          end else if (is_eop) begin
            state_d = ST_IDLE;
            if (cnt_q == CNT_TWO && crc5_q == CRC5_RESID) begin
              if (tok_addr_ok) begin
                addr_d        = tok_lo_q[6:0];
                endp_d        = {tok_hi_q, tok_lo_q[7]};
                frame_d       = {tok_hi_q, tok_lo_q};
                token_valid_d = 1'b1;
              end
            end else begin
              pkt_err_d = 1'b1;
            end
          end
        end

        ST_HSK: begin
          if (is_err) begin
            pkt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (is_byte) begin
            pkt_err_d = 1'b1;
            state_d   = ST_DROP;
          end else if (is_eop) begin
            hsk_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (is_err) begin
            data_end_d = 1'b1;
            pkt_err_d  = 1'b1;
            state_d    = ST_IDLE;
          end else if (is_byte) begin
            if (cnt_inc > LEN_MAX) begin
              data_end_d = 1'b1;
              pkt_err_d  = 1'b1;
              state_d    = ST_DROP;
            end else begin
              // Two bytes are always held back so the trailing CRC16 is never emitted.
              crc16_d = crc16_byte(crc16_q, phy.rx_data);
              cnt_d   = cnt_inc;
              dly0_d  = phy.rx_data;
              dly1_d  = dly0_q;
              if (cnt_q >= CNT_TWO) begin
                data_d       = dly1_q;
                data_valid_d = 1'b1;
              end
            end
          end else if (is_eop) begin
            data_end_d = 1'b1;
            data_ok_d  = data_good;
            pkt_err_d  = ~data_good;
            state_d    = ST_IDLE;
          end
        end

        ST_DROP: begin
          if (is_eop || is_err) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      pid_q         <= '0;
      addr_q        <= '0;
      endp_q        <= '0;
      frame_q       <= '0;
      tok_lo_q      <= '0;
      tok_hi_q      <= '0;
      cnt_q         <= '0;
      crc5_q        <= CRC5_INIT;
      crc16_q       <= CRC16_INIT;
      dly0_q        <= '0;
      dly1_q        <= '0;
      data_q        <= '0;
      token_valid_q <= 1'b0;
      hsk_valid_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      data_end_q    <= 1'b0;
      data_ok_q     <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      addr_q        <= addr_d;
      endp_q        <= endp_d;
      frame_q       <= frame_d;
      tok_lo_q      <= tok_lo_d;
      tok_hi_q      <= tok_hi_d;
      cnt_q         <= cnt_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      dly0_q        <= dly0_d;
      dly1_q        <= dly1_d;
      data_q        <= data_d;
      token_valid_q <= token_valid_d;
      hsk_valid_q   <= hsk_valid_d;
      data_valid_q  <= data_valid_d;
      data_end_q    <= data_end_d;
      data_ok_q     <= data_ok_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign pid_o         = pid_q;
  assign addr_o        = addr_q;
  assign endp_o        = endp_q;
  assign frame_o       = frame_q;
  assign token_valid_o = token_valid_q;
  assign hsk_valid_o   = hsk_valid_q;
  assign data_o        = data_q;
  assign data_valid_o  = data_valid_q;
  assign data_end_o    = data_end_q;
  assign data_ok_o     = data_ok_q;
  assign pkt_err_o     = pkt_err_q;

endmodule

// File: tb/tb_sie_rx_pkt.sv
// Randomized bench for sie_rx_pkt: packets are generated and scored per packet against a
// protocol-level model (CRC generate-and-compare, payload slicing by length).
module tb_sie_rx_pkt;
  localparam int MAX_PKT = 64;

`ifdef SIE_RX_ADDR_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        usb_reset;
  logic [6:0]  dev_addr;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frame;
  logic        token_valid;
  logic        hsk_valid;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_end;
  logic        data_ok;
  logic        pkt_err;

  sie_rx_pkt_if rx ();

  sie_rx_pkt #(.MAX_PKT(MAX_PKT)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .phy          (rx),
    .usb_reset_i  (usb_reset),
    .dev_addr_i   (dev_addr),
    .pid_o        (pid),
    .addr_o       (addr),
    .endp_o       (endp),
    .frame_o      (frame),
    .token_valid_o(token_valid),
    .hsk_valid_o  (hsk_valid),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_end_o   (data_end),
    .data_ok_o    (data_ok),
    .pkt_err_o    (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed events, appended by the monitor; expected events, appended by the model.
  logic [25:0] obs_tok[$], exp_tok[$];
  logic [3:0]  obs_hsk[$], exp_hsk[$];
  logic [7:0]  obs_dat[$], exp_dat[$];
  logic        obs_end[$], exp_end[$];
  int          obs_err = 0, exp_err = 0;
  int          tok_po = 0, tok_pe = 0, hsk_po = 0, hsk_pe = 0;
  int          dat_po = 0, dat_pe = 0, end_po = 0, end_pe = 0;
  int          err_po = 0, err_pe = 0;
  logic [25:0] last_tok = '0;

  always @(negedge clk) begin
    if (token_valid) obs_tok.push_back({pid, addr, endp, frame});
    if (hsk_valid)   obs_hsk.push_back(pid);
    if (data_valid)  obs_dat.push_back(data);
    if (data_end)    obs_end.push_back(data_ok);
    if (pkt_err)     obs_err++;
  end

  logic [7:0] pkt[$];
  bit         rand_gap;

  function automatic logic [4:0] crc5_gen(input logic [10:0] f);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[0] ^ f[i];
      c  = c >> 1;
      if (fb) c = c ^ 5'h14;
    end
    return ~c;
  endfunction

  // CRC16 field to transmit after payload bytes pkt[1..k].
  function automatic logic [15:0] crc16_gen(input int k);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 1; i <= k; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pkt[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return ~c;
  endfunction

  task automatic model_pkt(input bit term_err);
    logic [7:0]  p;
    logic [10:0] f;
    logic [15:0] c;
    int          n;
    bit          ok;
    p = pkt[0];
    n = pkt.size() - 1;
    if (p[7:4] != ~p[3:0] || p[1:0] == 2'b00) begin
      exp_err++;
    end else if (p[1:0] == 2'b01) begin
      if (n != 2 || term_err) begin
        exp_err++;
      end else begin
        f = {pkt[2][2:0], pkt[1]};
        if (pkt[2][7:3] != crc5_gen(f)) exp_err++;
        else if (!(FILT_EN && p[3:0] != 4'h5 && f[6:0] != dev_addr)) begin
          last_tok = {p[3:0], f[6:0], f[10:7], f};
          exp_tok.push_back(last_tok);
        end
      end
    end else if (p[1:0] == 2'b10) begin
      if (n == 0 && !term_err) exp_hsk.push_back(p[3:0]);
      else exp_err++;
    end else begin
      if (n > MAX_PKT + 2) begin
        for (int i = 1; i <= MAX_PKT; i++) exp_dat.push_back(pkt[i]);
        exp_end.push_back(1'b0);
        exp_err++;
      end else begin
        for (int i = 1; i <= n - 2; i++) exp_dat.push_back(pkt[i]);
        ok = 1'b0;
        if (!term_err && n >= 2) begin
          c  = crc16_gen(n - 2);
          ok = ({pkt[n], pkt[n-1]} == c);
        end
        exp_end.push_back(ok);
        if (!ok) exp_err++;
      end
    end
  endtask

  // kind: 0 byte, 1 EOP, 2 error. Garbage is left on valid/err/data while rx_ready is low.
  task automatic drive_sym(input int kind, input logic [7:0] d);
    @(negedge clk);
    rx.rx_ready = 1'b1;
    rx.rx_valid = (kind == 0);
    rx.rx_err   = (kind == 2);
    rx.rx_data  = d;
    @(negedge clk);
    rx.rx_ready = 1'b0;
    rx.rx_valid = 1'($urandom);
    rx.rx_err   = 1'($urandom);
    rx.rx_data  = 8'($urandom);
    if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_pkt(input bit term_err);
    foreach (pkt[i]) drive_sym(0, pkt[i]);
    drive_sym(term_err ? 2 : 1, 8'h00);
  endtask

  task automatic compare_pkt(input string tag);
    int no, ne;
    repeat (3) @(negedge clk);
    #1;
    no = obs_tok.size() - tok_po; ne = exp_tok.size() - tok_pe;
    check({tag, " token count"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++)
      check({tag, " token fields"}, 32'(obs_tok[tok_po+i]), 32'(exp_tok[tok_pe+i]));
    tok_po = obs_tok.size(); tok_pe = exp_tok.size();
    no = obs_hsk.size() - hsk_po; ne = exp_hsk.size() - hsk_pe;
    check({tag, " hsk count"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++)
      check({tag, " hsk pid"}, 32'(obs_hsk[hsk_po+i]), 32'(exp_hsk[hsk_pe+i]));
    hsk_po = obs_hsk.size(); hsk_pe = exp_hsk.size();
    no = obs_dat.size() - dat_po; ne = exp_dat.size() - dat_pe;
    check({tag, " data count"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++)
      check({tag, $sformatf(" data[%0d]", i)}, 32'(obs_dat[dat_po+i]), 32'(exp_dat[dat_pe+i]));
    dat_po = obs_dat.size(); dat_pe = exp_dat.size();
    no = obs_end.size() - end_po; ne = exp_end.size() - end_pe;
    check({tag, " data_end count"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++)
      check({tag, " data_ok"}, 32'(obs_end[end_po+i]), 32'(exp_end[end_pe+i]));
    end_po = obs_end.size(); end_pe = exp_end.size();
    check({tag, " pkt_err count"}, 32'(obs_err - err_po), 32'(exp_err - err_pe));
    err_po = obs_err; err_pe = exp_err;
  endtask

  task automatic run_pkt(input string tag, input bit term_err);
    model_pkt(term_err);
    send_pkt(term_err);
    compare_pkt(tag);
  endtask

  task automatic build_token(input logic [3:0] p, input logic [10:0] f);
    pkt.delete();
    pkt.push_back({~p, p});
    pkt.push_back(f[7:0]);
    pkt.push_back({crc5_gen(f), f[10:8]});
  endtask

  task automatic build_data(input logic [3:0] p, input int len);
    logic [15:0] c;
    pkt.delete();
    pkt.push_back({~p, p});
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    c = crc16_gen(len);
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
  endtask

  task automatic gen_random(output bit term_err);
    int          kind, len, idx;
    logic [3:0]  p;
    logic [10:0] f;
    kind = $urandom_range(0, 9);
    if (kind <= 2) begin
      p = {2'($urandom), 2'b01};
      f = 11'($urandom);
      if ($urandom_range(0, 1) == 1) f[6:0] = dev_addr;
      build_token(p, f);
      case ($urandom_range(0, 9))
        0: begin idx = $urandom_range(1, 2); pkt[idx] = pkt[idx] ^ 8'(1 << $urandom_range(0, 7)); end
        1: pkt.push_back(8'($urandom));
        2: void'(pkt.pop_back());
        default: ;
      endcase
    end else if (kind == 3) begin
      p = {2'($urandom), 2'b10};
      pkt.delete();
      pkt.push_back({~p, p});
      if ($urandom_range(0, 4) == 0) pkt.push_back(8'($urandom));
    end else if (kind <= 7) begin
      p   = {2'($urandom), 2'b11};
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(MAX_PKT - 4, MAX_PKT + 3) : $urandom_range(0, 12);
      build_data(p, len);
      case ($urandom_range(0, 7))
        0: begin idx = $urandom_range(1, pkt.size() - 1); pkt[idx] = pkt[idx] ^ 8'(1 << $urandom_range(0, 7)); end
        1: void'(pkt.pop_back());
        default: ;
      endcase
    end else begin
      pkt.delete();
      p = 4'($urandom);
      if (kind == 8) pkt.push_back({p, p});
      else pkt.push_back({~{p[3:2], 2'b00}, {p[3:2], 2'b00}});
      repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
    end
    term_err = ($urandom_range(0, 11) == 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [7:0] t2 [11];
  bit         te;

  initial begin
    t2 = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    rstn        = 1'b0;
    usb_reset   = 1'b0;
    dev_addr    = 7'd0;
    rand_gap    = 1'b0;
    rx.rx_ready = 1'b0;
    rx.rx_valid = 1'b0;
    rx.rx_err   = 1'b0;
    rx.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset fields", 32'({pid, addr, endp, frame}), 32'd0);
    check("reset pulses", 32'({data, token_valid, hsk_valid, data_valid, data_end, data_ok, pkt_err}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // SETUP addr 0 endp 0, with pulse latency and width checked directly.
    build_token(4'hD, 11'd0);
    check("t1 setup crc byte", 32'(pkt[2]), 32'h10);
    model_pkt(1'b0);
    foreach (pkt[i]) drive_sym(0, pkt[i]);
    @(negedge clk);
    rx.rx_ready = 1'b1; rx.rx_valid = 1'b0; rx.rx_err = 1'b0;
    @(posedge clk); #1;
    check("t1 token_valid latency", 32'(token_valid), 32'd1);
    check("t1 pid", 32'(pid), 32'hD);
    @(negedge clk);
    rx.rx_ready = 1'b0;
    @(posedge clk); #1;
    check("t1 token_valid width", 32'(token_valid), 32'd0);
    compare_pkt("t1");

    pkt.delete();
    foreach (t2[i]) pkt.push_back(t2[i]);
    run_pkt("t2 data0 good", 1'b0);
    pkt[10] = 8'h95;
    run_pkt("t3 data0 bad crc", 1'b0);

    pkt.delete(); pkt.push_back(8'hD2);
    run_pkt("t4 ack", 1'b0);
    pkt.delete(); pkt.push_back(8'hD3); pkt.push_back(8'hAA); pkt.push_back(8'h55);
    run_pkt("t4 bad pid", 1'b0);
    build_token(4'hD, 11'd0);
    run_pkt("t4 setup after drop", 1'b0);

    pkt.delete(); pkt.push_back(8'h4B);
    repeat (67) pkt.push_back(8'($urandom));
    run_pkt("t5 overlong", 1'b0);
    build_data(4'h3, 0);
    run_pkt("t5 zero length", 1'b0);

    // Bus reset in the middle of a data packet: one byte already left the delay line.
    build_data(4'h3, 1);
    model_pkt(1'b0);
    exp_end.delete(end_pe); exp_err = err_pe;
    foreach (pkt[i]) drive_sym(0, pkt[i]);
    @(negedge clk); usb_reset = 1'b1;
    @(negedge clk); usb_reset = 1'b0;
    compare_pkt("t6 usb_reset");
    check("t6 fields hold", 32'({addr, endp, frame}), 32'(last_tok[21:0]));
    build_token(4'h9, 11'h2A3);
    run_pkt("t6 token after reset", 1'b0);
    pkt.delete(); pkt.push_back(8'h2D); pkt.push_back(8'h00);
    run_pkt("t6 err mid token", 1'b1);
    build_token(4'hD, 11'd0);
    run_pkt("t6 token after err", 1'b0);

    dev_addr = 7'd5;
`ifdef SIE_RX_ADDR_FILTER_EN
    build_token(4'hD, 11'd0);
    run_pkt("t6 filtered setup", 1'b0);
    check("t6 filtered fields hold", 32'({addr, endp, frame}), 32'(last_tok[21:0]));
    build_token(4'h1, {4'd3, 7'd5});
    run_pkt("t6 matching out", 1'b0);
    build_token(4'h5, 11'h7FF);
    run_pkt("t6 sof always", 1'b0);
`endif

    rand_gap = 1'b1;
    for (int k = 0; k < 400; k++) begin
      gen_random(te);
      run_pkt($sformatf("rnd%0d", k), te);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
